// File: rtl/dsp_product_capture.sv
// Capture stage for the flattened DSP product buses: waits for the pipeline to settle,
// snapshots the products once they stop changing, and serves them through a 32-bit read port.
module dsp_product_capture #(
    parameter int NPROD     = 5,
    parameter int SETTLE    = 4,
    parameter int STABLE    = 2,
    parameter int TIMEOUT   = 255,
    parameter bit AUTOSTART = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NPROD*64-1:0] prod_bus,
    input  logic                start,
    input  logic                rd_en,
    input  logic [3:0]          rd_addr,
    output logic [31:0]         rd_data,
    output logic                rd_valid,
    output logic                done,
    output logic                busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [NPROD*64-1:0] r_snap;
    logic [15:0]         r_settleCnt;
    logic [15:0]         r_matchCnt;
    logic [15:0]         r_sampCnt;
    logic                r_timeout;
    logic                r_autoPend;
    logic                w_arm;
    logic                w_equal;
    logic                w_firstSample;
    logic                w_compare;
    logic                w_timeoutHit;
    logic [31:0]         w_rdWord;

    // r_autoPend is set by reset so the first cycle after release arms the capture.
    assign w_arm   = start | (AUTOSTART & r_autoPend);
    assign w_equal = (prod_bus == r_snap);
    assign done    = (r_state == S_DONE);
    assign busy    = (r_state == S_SETTLE) || (r_state == S_SAMPLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState   = r_state;
        w_firstSample = 1'b0;
        w_compare     = 1'b0;
        w_timeoutHit  = 1'b0;
        case (r_state)
            S_SETTLE: begin
                if (r_settleCnt == 16'(SETTLE - 1)) begin
                    w_nextState = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (r_sampCnt == 16'd0) begin
                    w_firstSample = 1'b1;
                end else if (r_sampCnt == 16'(TIMEOUT)) begin
                    w_timeoutHit = 1'b1;
                    w_nextState  = S_DONE;
                end else begin
                    w_compare = 1'b1;
                    if (w_equal && ((r_matchCnt + 16'd1) == 16'(STABLE))) begin
                        w_nextState = S_DONE;
                    end
                end
            end
            default: ;
        endcase
        if (w_arm) begin
            w_nextState = S_SETTLE;
        end
    end

    // Arming clears the flags and counters but leaves the old snapshot readable until
    // the first sample of the new capture overwrites it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_snap      <= '0;
            r_settleCnt <= 16'd0;
            r_matchCnt  <= 16'd0;
            r_sampCnt   <= 16'd0;
            r_timeout   <= 1'b0;
            r_autoPend  <= 1'b1;
        end else begin
            r_autoPend <= 1'b0;
            if (w_arm) begin
                r_settleCnt <= 16'd0;
                r_matchCnt  <= 16'd0;
                r_sampCnt   <= 16'd0;
                r_timeout   <= 1'b0;
            end else begin
                if (r_state == S_SETTLE) begin
                    r_settleCnt <= r_settleCnt + 16'd1;
                end
                if (w_firstSample) begin
                    r_snap     <= prod_bus;
                    r_matchCnt <= 16'd0;
                    r_sampCnt  <= 16'd1;
                end
                if (w_timeoutHit) begin
                    r_timeout <= 1'b1;
                end
                if (w_compare) begin
                    r_snap     <= prod_bus;
                    r_sampCnt  <= r_sampCnt + 16'd1;
                    r_matchCnt <= w_equal ? (r_matchCnt + 16'd1) : 16'd0;
                end
            end
        end
    end

    // Word a of the snapshot sits at bit 32*a of the flattened bus.
    always_comb begin
        w_rdWord = 32'd0;
        for (int w = 0; w < 2 * NPROD; w++) begin
            if (rd_addr == 4'(w)) begin
                w_rdWord = r_snap[32*w +: 32];
            end
        end
        if (rd_addr == 4'd14) begin
            w_rdWord = {r_sampCnt, 13'd0, r_timeout, busy, done};
        end
        if (rd_addr == 4'd15) begin
            w_rdWord = 32'hD590_0000 | 32'(NPROD);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data  <= 32'd0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= w_rdWord;
            end
        end
    end

endmodule

// File: tb/tb_dsp_product_capture.sv
// Self-checking bench for dsp_product_capture: spec vectors, corner-case sequences and
// a randomized run checked against a sample-history reference model.
module tb_dsp_product_capture;

    localparam int NPROD   = 5;
    localparam int SETTLE  = 4;
    localparam int STABLE  = 2;
    localparam int TIMEOUT = 20;
    localparam int BW      = NPROD * 64;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          rd_en = 1'b0;
    logic [3:0]    rd_addr = 4'd0;
    logic [BW-1:0] prod_bus = '0;
    logic [31:0]   rd_data;
    logic          rd_valid;
    logic          done;
    logic          busy;

    dsp_product_capture #(
        .NPROD(NPROD), .SETTLE(SETTLE), .STABLE(STABLE),
        .TIMEOUT(TIMEOUT), .AUTOSTART(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .prod_bus(prod_bus), .start(start),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: a capture is the list of samples taken since arming; done when the last
    // STABLE+1 samples agree, or when TIMEOUT samples have been taken.
    bit            mAuto = 1'b0;
    bit            mArmed = 1'b0;
    int            mAge = 0;
    logic [BW-1:0] mSamples[$];
    bit            mDone = 1'b0;
    bit            mTimeout = 1'b0;
    logic [BW-1:0] mSnap = '0;
    logic [31:0]   mRd = 32'd0;
    bit            mRdValid = 1'b0;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] exp;
    } readVec_t;
    readVec_t vecs[11];

    function automatic logic [31:0] modelWord(input logic [3:0] a);
        logic [BW-1:0] s;
        if (a == 4'd14) return {16'(mSamples.size()), 13'd0, mTimeout, (mArmed && !mDone), mDone};
        if (a == 4'd15) return 32'hD590_0005;
        if (int'(a) < 2 * NPROD) begin
            s = mSnap >> (32 * int'(a));
            return s[31:0];
        end
        return 32'd0;
    endfunction

    task automatic modelStep();
        bit allEq;
        if (!reset) begin
            mRdValid = 1'b0; mRd = 32'd0; mAuto = 1'b1; mArmed = 1'b0; mAge = 0;
            mSamples.delete(); mDone = 1'b0; mTimeout = 1'b0; mSnap = '0;
            return;
        end
        mRdValid = rd_en;
        if (rd_en) mRd = modelWord(rd_addr);
        if (start || mAuto) begin
            mArmed = 1'b1; mAge = 0; mSamples.delete(); mDone = 1'b0; mTimeout = 1'b0;
        end else if (mArmed && !mDone) begin
            mAge++;
            if (mAge > SETTLE) begin
                if (mSamples.size() == TIMEOUT) begin
                    mDone = 1'b1; mTimeout = 1'b1;
                end else begin
                    mSamples.push_back(prod_bus);
                    mSnap = prod_bus;
                    if (mSamples.size() >= STABLE + 1) begin
                        allEq = 1'b1;
                        for (int i = mSamples.size() - STABLE - 1; i < mSamples.size(); i++)
                            if (mSamples[i] != prod_bus) allEq = 1'b0;
                        if (allEq) mDone = 1'b1;
                    end
                end
            end
        end
        mAuto = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkAll();
        checkOutput("done", 32'(done), 32'(mDone));
        checkOutput("busy", 32'(busy), 32'(mArmed && !mDone));
        checkOutput("rd_valid", 32'(rd_valid), 32'(mRdValid));
        checkOutput("rd_data", rd_data, mRd);
    endtask

    task automatic stepClock();
        @(posedge clk);
        modelStep();
        #1;
        checkAll();
    endtask

    task automatic applyStimulus(input logic rst, input logic st, input logic re,
                                 input logic [3:0] a, input logic [BW-1:0] bus);
        reset = rst; start = st; rd_en = re; rd_addr = a; prod_bus = bus;
    endtask

    task automatic waitDone(input int maxCycles, output int n);
        n = 0;
        while (!done && n < maxCycles) begin
            stepClock();
            n++;
        end
    endtask

    task automatic doRead(input logic [3:0] a, output logic [31:0] d);
        rd_en = 1'b1; rd_addr = a;
        stepClock();
        d = rd_data;
        rd_en = 1'b0;
    endtask

    function automatic logic [BW-1:0] randBus();
        logic [BW-1:0] b;
        for (int i = 0; i < BW / 32; i++) b[32*i +: 32] = $urandom();
        return b;
    endfunction

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int            n;
        logic [31:0]   d;
        logic [BW-1:0] bus1;
        logic [BW-1:0] poolA;
        logic [BW-1:0] poolB;

        vecs[0]  = '{4'd0,  32'h0000_0013};
        vecs[1]  = '{4'd1,  32'h0000_0000};
        vecs[2]  = '{4'd2,  32'h0000_00D2};
        vecs[3]  = '{4'd3,  32'h0000_0000};
        vecs[4]  = '{4'd8,  32'hFFFD_6000};
        vecs[5]  = '{4'd9,  32'hFFFF_FFFF};
        vecs[6]  = '{4'd10, 32'h0000_0000};
        vecs[7]  = '{4'd12, 32'h0000_0000};
        vecs[8]  = '{4'd13, 32'h0000_0000};
        vecs[9]  = '{4'd14, 32'h0003_0001};
        vecs[10] = '{4'd15, 32'hD590_0005};

        bus1 = '0;
        bus1[63:0]    = 64'h13;
        bus1[127:64]  = 64'hD2;
        bus1[319:256] = 64'hFFFF_FFFF_FFFD_6000;

        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, bus1);
        repeat (3) stepClock();
        checkOutput("reset rd_data", rd_data, 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);

        reset = 1'b1;
        stepClock();
        waitDone(50, n);
        checkOutput("autostart latency", 32'(n), 32'd7);

        for (int i = 0; i < 11; i++) begin
            doRead(vecs[i].addr, d);
            checkOutput($sformatf("table addr %0d", vecs[i].addr), d, vecs[i].exp);
        end

        // Accumulating product never settles: timeout after TIMEOUT samples.
        prod_bus = '0;
        start = 1'b1;
        stepClock();
        start = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            prod_bus[63:0] = prod_bus[63:0] + 64'd1;
            stepClock();
            n++;
        end
        checkOutput("timeout latency", 32'(n), 32'(SETTLE + 1 + TIMEOUT));
        doRead(4'd14, d);
        checkOutput("timeout status", d, 32'h0014_0005);
        doRead(4'd0, d);
        checkOutput("timeout last sample", d, mSnap[31:0]);

        // One-cycle glitch on the second sample.
        prod_bus = '0;
        prod_bus[63:0] = 64'h30000;
        start = 1'b1;
        stepClock();
        start = 1'b0;
        repeat (5) stepClock();
        prod_bus[63:0] = 64'h0;
        stepClock();
        prod_bus[63:0] = 64'h30000;
        waitDone(50, n);
        checkOutput("glitch latency", 32'(n + 6), 32'd9);
        doRead(4'd14, d);
        checkOutput("glitch status", d, 32'h0005_0001);
        doRead(4'd0, d);
        checkOutput("glitch snap", d, 32'h0003_0000);

        // Restart in the middle of SAMPLE.
        start = 1'b1;
        stepClock();
        start = 1'b0;
        repeat (5) stepClock();
        start = 1'b1;
        stepClock();
        start = 1'b0;
        checkOutput("restart done low", 32'(done), 32'd0);
        checkOutput("restart busy high", 32'(busy), 32'd1);
        waitDone(50, n);
        checkOutput("restart latency", 32'(n), 32'd7);

        // Start and read together: read sees the pre-restart status.
        start = 1'b1; rd_en = 1'b1; rd_addr = 4'd14;
        stepClock();
        start = 1'b0; rd_en = 1'b0;
        checkOutput("status at restart", rd_data, 32'h0003_0001);
        checkOutput("busy after restart", 32'(busy), 32'd1);

        // One-cycle reset during SETTLE.
        repeat (2) stepClock();
        reset = 1'b0;
        stepClock();
        checkOutput("mid reset done", 32'(done), 32'd0);
        checkOutput("mid reset busy", 32'(busy), 32'd0);
        checkOutput("mid reset rd_data", rd_data, 32'd0);
        checkOutput("mid reset rd_valid", 32'(rd_valid), 32'd0);
        reset = 1'b1; rd_en = 1'b1; rd_addr = 4'd0;
        stepClock();
        rd_en = 1'b0;
        checkOutput("snap cleared by reset", rd_data, 32'd0);
        waitDone(50, n);
        checkOutput("recapture latency", 32'(n), 32'd7);
        doRead(4'd0, d);
        checkOutput("recapture snap", d, 32'h0003_0000);

        // Randomized traffic against the model.
        poolA = randBus();
        poolB = randBus();
        for (int c = 0; c < 3000; c++) begin
            n = $urandom_range(0, 99);
            if (n < 8) prod_bus = poolA;
            else if (n < 15) prod_bus = poolB;
            else if (n < 17) prod_bus = randBus();
            applyStimulus(($urandom_range(0, 299) != 0), ($urandom_range(0, 49) == 0),
                          1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), prod_bus);
            stepClock();
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, prod_bus);
        stepClock();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
